// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the bit-serial adder.
// State encoding is fixed so the FSM can be probed against older tooling.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter wide enough to hold values 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit combinational full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit operands added LSB-first through one full_adder
// cell and a carry flop. Result and carry register together with a one-cycle
// done pulse; start is honoured only in IDLE or DONE.
// Optional build macro SERIAL_ADDER_SUB_EN adds the sub input (two's
// complement subtract) and the ovf signed-overflow output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] psum_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic             accept;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  // One full-adder cell does all the arithmetic; it always sees bit 0 of
  // the shift registers and the current carry.
  full_adder u_fa (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign accept   = start && (state_reg != RUN);
  assign last_bit = (state_reg == RUN) && (cnt_reg == LAST);

  // Effective B and initial carry: subtract is A + ~B + 1, cin ignored.
  always_comb begin
    b_load = b;
    c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end
`endif
  end

  // FSM and status flags; done is a single-cycle pulse on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          if (last_bit) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Operand shift registers, carry flop, partial sum and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      psum_reg  <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (accept) begin
      a_sh_reg  <= a;
      b_sh_reg  <= b_load;
      carry_reg <= c_load;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_sh_reg  <= {1'b0, a_sh_reg[WIDTH-1:1]};
      b_sh_reg  <= {1'b0, b_sh_reg[WIDTH-1:1]};
      psum_reg  <= {fa_s, psum_reg[WIDTH-1:1]};
      carry_reg <= fa_c;
      cnt_reg   <= cnt_reg + CW'(1);
    end
  end

  // Result registers update only on the final bit and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else if (last_bit) begin
      sum_reg  <= {fa_s, psum_reg[WIDTH-1:1]};
      cout_reg <= fa_c;
    end
  end

`ifdef SERIAL_ADDER_SUB_EN
  logic ovf_reg;

  // On the last bit the cell inputs are the operand MSBs and fa_s is the
  // result MSB, so overflow is decided without storing the MSBs separately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (last_bit) begin
      ovf_reg <= (a_sh_reg[0] == b_sh_reg[0]) && (fa_s != a_sh_reg[0]);
    end
  end

  assign ovf = ovf_reg;
`endif

  assign busy = busy_reg;
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder against an
// arithmetic reference model (integer add/subtract, signed range test).
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Operands of the operation most recently started, and the last result.
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_cin, op_sub;
  logic [WIDTH-1:0] last_sum;
  logic             last_cout;
  logic             last_ovf;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
    .ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a start request at the current (negedge) time.
  task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tcin, input logic tsub);
    op_a   = ta;
    op_b   = tb;
    op_cin = tcin;
    op_sub = tsub;
    a      = ta;
    b      = tb;
    cin    = tcin;
`ifdef SERIAL_ADDER_SUB_EN
    sub    = tsub;
`endif
    start  = 1'b1;
  endtask

  // Follow a started operation through RUN into its DONE cycle; optionally
  // re-assert start with a bogus operand at RUN cycle inject_at.
  task automatic expect_run(input string tag, input int inject_at);
    longint unsigned ua, ub, total;
    longint          sa, sb, stot;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout, exp_ovf;
    ua    = longint'(op_a);
    ub    = op_sub ? ((longint'(1) << WIDTH) - 1 - longint'(op_b)) : longint'(op_b);
    total = ua + ub + (op_sub ? 1 : longint'(op_cin));
    exp_sum  = WIDTH'(total % (longint'(1) << WIDTH));
    exp_cout = ((total >> WIDTH) != 0);
    sa   = (ua >= (longint'(1) << (WIDTH - 1))) ? longint'(ua) - (longint'(1) << WIDTH) : longint'(ua);
    sb   = (ub >= (longint'(1) << (WIDTH - 1))) ? longint'(ub) - (longint'(1) << WIDTH) : longint'(ub);
    stot = sa + sb + (op_sub ? 1 : longint'(op_cin));
    exp_ovf = (stot > (longint'(1) << (WIDTH - 1)) - 1) || (stot < -(longint'(1) << (WIDTH - 1)));
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      cin   = 1'($urandom);
      if (i == inject_at) begin
        start = 1'b1;
        a     = '1;
      end
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_nodone"}, done, 1'b0);
      chk({tag, "_sumhold"}, sum, last_sum);
      chk({tag, "_couthold"}, cout, last_cout);
    end
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_low"}, busy, 1'b0);
    chk({tag, "_sum"}, sum, exp_sum);
    chk({tag, "_cout"}, cout, exp_cout);
`ifdef SERIAL_ADDER_SUB_EN
    chk({tag, "_ovf"}, ovf, exp_ovf);
`endif
    last_sum  = exp_sum;
    last_cout = exp_cout;
    last_ovf  = exp_ovf;
    $display("op %s a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d ovf=%0d",
             tag, op_a, op_b, op_cin, op_sub, exp_sum, exp_cout, exp_ovf);
  endtask

  // One cycle after DONE with no new start: pulse gone, result held.
  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_pulse_end"}, done, 1'b0);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_sum"}, sum, last_sum);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    op_sub = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif
    last_sum  = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_cout", cout, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    chk("rst_ovf", ovf, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);

    start_op(8'h00, 8'h00, 1'b0, 1'b0); expect_run("zero", -1);   idle_chk("zero");
    start_op(8'hFF, 8'h01, 1'b0, 1'b0); expect_run("wrap", -1);   idle_chk("wrap");
    start_op(8'hA5, 8'h5A, 1'b1, 1'b0); expect_run("a5_5a", -1);  idle_chk("a5_5a");
    start_op(8'h03, 8'h04, 1'b0, 1'b0); expect_run("inject", 3);  idle_chk("inject");

    // Abort with reset in the middle of RUN.
    start_op(8'h5C, 8'h33, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_sum", sum, '0);
    chk("abort_cout", cout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    last_sum  = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(negedge clk);
      chk("abort_nodone", done, 1'b0);
    end
    $display("op abort: reset during RUN, no completion");

    start_op(8'h12, 8'h34, 1'b0, 1'b0); expect_run("post_rst", -1);
    start_op(8'h10, 8'h20, 1'b0, 1'b0); expect_run("b2b", -1);    idle_chk("b2b");

`ifdef SERIAL_ADDER_SUB_EN
    start_op(8'h10, 8'h01, 1'b0, 1'b1); expect_run("sub_10_01", -1); idle_chk("sub_10_01");
    start_op(8'h80, 8'h01, 1'b1, 1'b1); expect_run("sub_80_01", -1); idle_chk("sub_80_01");
    start_op(8'h7F, 8'h01, 1'b0, 1'b0); expect_run("add_ovf", -1);   idle_chk("add_ovf");
`endif

    // Random operations, sometimes back-to-back from the DONE cycle.
    for (int n = 0; n < 24; n++) begin
      logic r_sub;
      r_sub = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      r_sub = 1'($urandom);
`endif
      if ($urandom_range(0, 1) == 0) idle_chk("rnd");
      start_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), r_sub);
      expect_run("rnd", ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIDTH - 2)) : -1);
    end
    idle_chk("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder: captures two WIDTH-bit operands on a start pulse, adds them LSB-first through one full-adder cell and a carry flip-flop, and reports the registered result with a one-cycle done pulse. It is the sequential, area-minimal successor to the combinational single-bit full adder. It sits in the arithmetic datapath wherever latency can be traded for gate count.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..64
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin an operation; sampled only in IDLE or DONE
- a  input  WIDTH  operand A, captured on the accepted start
- b  input  WIDTH  operand B, captured on the accepted start
- cin  input  1  carry-in, captured on the accepted start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse; sum/cout are valid from this cycle onward
- sum  output  WIDTH  registered result; holds until the next completion
- cout  output  1  registered carry-out; holds with sum
- sub  input  1  subtract select, captured on start (SERIAL_ADDER_SUB_EN only)
- ovf  output  1  signed overflow of the last result (SERIAL_ADDER_SUB_EN only)

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: load shift registers with a and b, set carry flop to cin, clear the bit counter, then go to RUN. With start=0, stay in IDLE.
- RUN: on each edge, process bit 0 of both shift registers.
  - s = a0^b0^c; c' = majority(a0, b0, c).
  - Shift the a/b registers right by one; shift s into the MSB of a partial-sum register.
  - Increment the counter (width $clog2(WIDTH+1)).
- RUN exit: on the edge that processes bit WIDTH-1, copy the partial sum into sum, copy c' into cout, and go to DONE.
- DONE: done=1 for exactly one cycle. start=1 here is accepted (back-to-back, same actions as in IDLE); otherwise go to IDLE.
- start during RUN is ignored; operands and cin are not re-sampled.
- a, b, cin and sub need to be valid only in the cycle start is accepted.
- Result is modulo 2^WIDTH. cout is the true carry out of bit WIDTH-1.

## Timing
- Reset (async assert, any state): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; counter, carry and shift registers cleared.
- Reset during RUN aborts the operation; no done pulse is issued.
- Latency: start accepted at edge k. busy=1 after edges k..k+WIDTH-1. Result and done register at edge k+WIDTH. busy=0 in the done cycle.
- Throughput: one result every WIDTH+1 cycles (back-to-back via DONE).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Adds the sub input and ovf output.
  - sub=1 at start: B is loaded inverted, the carry flop is loaded with 1, and cin is ignored. The result is a-b; cout=1 means no borrow.
  - ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the effective B. ovf registers with sum in both add and subtract modes.
- SERIAL_ADDER_SUB_EN undefined: no sub/ovf ports; add-only datapath as described above.

## Structure
- Package serial_adder_pkg:
  - State enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Counter-width helper function.
- Sub-module: instantiate the existing single-bit full_adder cell for the s/c' computation. The carry flop, shift registers and FSM stay in serial_adder.

## Test plan
- WIDTH=8, a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0; done exactly 8 edges after the start edge; busy high for 8 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
- Start a=0x03, b=0x04; re-assert start with a=0xFF mid-RUN -> sum=0x07; only one done pulse.
- Assert rst at RUN cycle 4 -> all outputs 0 immediately; no done. A new start after reset gives the correct result.
- Back-to-back: start in the DONE cycle with a=0x10, b=0x20 -> done 8 edges later, sum=0x30; the previous sum holds until then.
- SERIAL_ADDER_SUB_EN: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1, ovf=0. sub=1, a=0x80, b=0x01 -> sum=0x7F, ovf=1.
